// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fetch_pkg
// Purpose  : Shared types and constants for the instruction-fetch front end.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int          FETCH_XLEN = 32;
    localparam int          INSTR_W    = 32;
    localparam int          PC_STEP    = 4;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [INSTR_W-1:0]    instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue_unit_if.sv
`default_nettype none
// ============================================================================
// Interface : fetch_queue_unit_if
// Purpose   : Instruction-memory, redirect and IF/ID handshake bundle.
// Revision  : 1.0 - initial release
// ============================================================================
interface fetch_queue_unit_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    logic                     imem_req;
    logic [XLEN-1:0]          imem_addr;
    logic                     imem_ack;
    logic [31:0]              imem_rdata;
    logic                     redirect;
    logic [XLEN-1:0]          redirect_pc;
    logic                     id_ready;
    logic                     if_valid;
    logic [XLEN-1:0]          if_pc;
    logic [XLEN-1:0]          if_pc_plus4;
    logic [31:0]              if_instr;
    logic [$clog2(DEPTH):0]   q_count;

    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_pc_plus4, if_instr, q_count,
        input  imem_ack, imem_rdata, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_pc_plus4, if_instr, q_count,
        output imem_ack, imem_rdata, redirect, redirect_pc, id_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Synchronous FIFO with push/pop/clear and occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   i_push,
    input  wire logic                   i_pop,
    input  wire logic                   i_clear,
    input  wire logic [WIDTH-1:0]       i_wdata,
    output logic      [WIDTH-1:0]       o_rdata,
    output logic      [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && (r_count != (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop  && (r_count != '0);
    assign o_rdata   = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_unit
// Purpose  : Fetch PC owner, one-outstanding IMEM requester and decoupling
//            queue feeding IF/ID. Optional macro FETCH_BYPASS_EN forwards the
//            returning word straight to IF_* when the queue is empty.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input wire logic           clk,
    input wire logic           rst_n,
    fetch_queue_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = XLEN + INSTR_W;

    fetch_state_t       r_state;
    logic               r_req;
    logic [XLEN-1:0]    r_addr;
    logic [XLEN-1:0]    r_target;
    logic [XLEN-1:0]    r_last_pc;
    logic [INSTR_W-1:0] r_last_instr;

    logic [EW-1:0]      w_head;
    logic [CW-1:0]      w_count;
    logic [CW:0]        w_count_next;
    logic [XLEN-1:0]    w_redir_pc;
    logic               w_ack_live;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;
    logic               w_slot_free;
    logic               w_if_valid;
    logic [XLEN-1:0]    w_if_pc;
    logic [INSTR_W-1:0] w_if_instr;

    assign w_redir_pc = bus.redirect_pc & ~XLEN'(3);
    assign w_ack_live = (r_state == REQ) && r_req && bus.imem_ack;

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_ack_live && (w_count == '0) && bus.id_ready && !bus.redirect;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = w_ack_live && !bus.redirect && !w_bypass;
    assign w_pop  = (w_count != '0) && bus.id_ready && !bus.redirect;

    // Occupancy after this edge; a new request is only issued into a reserved slot.
    assign w_count_next = {1'b0, w_count} + (CW+1)'(w_push) - (CW+1)'(w_pop);
    assign w_slot_free  = w_count_next < (CW+1)'(DEPTH);

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (bus.redirect),
        .i_wdata ({r_addr, bus.imem_rdata}),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_req    <= 1'b0;
            r_addr   <= RESET_PC;
            r_target <= RESET_PC;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= REQ;
                    if (bus.redirect) r_addr <= w_redir_pc;
                end
                REQ: begin
                    if (bus.redirect) begin
                        // An unanswered request must complete before the address may move.
                        if (r_req && !bus.imem_ack) begin
                            r_state  <= DROP;
                            r_target <= w_redir_pc;
                        end else begin
                            r_addr <= w_redir_pc;
                            r_req  <= 1'b1;
                        end
                    end else if (!r_req || bus.imem_ack) begin
                        if (r_req) r_addr <= r_addr + XLEN'(PC_STEP);
                        r_req <= w_slot_free;
                    end
                end
                DROP: begin
                    if (bus.imem_ack) begin
                        r_addr  <= bus.redirect ? w_redir_pc : r_target;
                        r_req   <= 1'b1;
                        r_state <= REQ;
                    end else if (bus.redirect) begin
                        r_target <= w_redir_pc;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // Last consumed word, shown on IF_* while the queue is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_pc    <= '0;
            r_last_instr <= '0;
        end else if (w_pop || w_bypass) begin
            r_last_pc    <= w_if_pc;
            r_last_instr <= w_if_instr;
        end
    end

    always_comb begin
        w_if_valid = (w_count != '0);
        w_if_pc    = r_last_pc;
        w_if_instr = r_last_instr;
        if (w_count != '0) {w_if_pc, w_if_instr} = w_head;
        if (w_bypass) begin
            w_if_valid = 1'b1;
            w_if_pc    = r_addr;
            w_if_instr = bus.imem_rdata;
        end
    end

    assign bus.imem_req    = r_req;
    assign bus.imem_addr   = r_addr;
    assign bus.if_valid    = w_if_valid;
    assign bus.if_pc       = w_if_pc;
    assign bus.if_pc_plus4 = w_if_pc + XLEN'(PC_STEP);
    assign bus.if_instr    = w_if_instr;
    assign bus.q_count     = w_count;

endmodule
`default_nettype wire
